// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the instruction-memory loader.
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W = 16;
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE, ERR
  } loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake in, instruction-memory write port out.
interface imem_loader_if #(parameter int ADDR_W = 6) ();
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (output byte_in, byte_valid, input byte_ready, imem_we, imem_addr, imem_wdata);
  modport slave (input byte_in, byte_valid, output byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: gathers four little-endian bytes into a registered 32-bit word with a one-cycle valid.
module word_packer import imem_loader_pkg::*; (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic push,
  input  logic [7:0] din,
  output logic last_byte,
  output logic word_valid,
  output logic [31:0] word
);
  logic [1:0] cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  logic [31:0] word_q, word_d;
  logic valid_q, valid_d;
  always_comb begin
    last_byte = cnt_q == 2'(BYTES_PER_WORD - 1);
    cnt_d = clr ? '0 : push ? cnt_q + 2'd1 : cnt_q;
    sr_d = clr ? '0 : (push && !last_byte) ? {din, sr_q[23:8]} : sr_q;
    word_d = clr ? '0 : (push && last_byte) ? {din, sr_q} : word_q;
    valid_d = !clr && push && last_byte;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sr_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      word_q <= word_d;
      valid_q <= valid_d;
    end
  end
  assign word = word_q;
  assign word_valid = valid_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream loader for instruction memory; holds the core in reset until loaded.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match for the load to succeed.
module imem_loader import imem_loader_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  imem_loader_if.slave bus,
  output logic cpu_hold,
  output logic done,
  output logic error,
  output logic [ADDR_W:0] word_count
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL = CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam loader_state_t TAIL = DONE;
`endif
  loader_state_t state_q, state_d;
  logic [7:0] len_lo_q, len_lo_d;
  logic [ADDR_W:0] len_q, len_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_n;
  logic accept, restart, push, last_byte, word_valid;
  logic [31:0] word;
  word_packer u_packer (
    .clock, .reset_n, .clr(restart), .push, .din(bus.byte_in),
    .last_byte, .word_valid, .word
  );
  assign bus.byte_ready = !(state_q == IDLE || state_q == DONE || state_q == ERR);
  always_comb begin
    len_n = {bus.byte_in, len_lo_q};
    accept = bus.byte_valid && bus.byte_ready;
    restart = start && !bus.byte_ready;
    push = accept && state_q == DATA;
    state_d = state_q;
    len_lo_d = len_lo_q;
    len_d = len_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d = restart ? '0 : push ? csum_q ^ bus.byte_in : csum_q;
`endif
    if (restart) begin
      state_d = LEN_LO;
      cnt_d = '0;
    end else if (accept) begin
      case (state_q)
        LEN_LO: begin
          len_lo_d = bus.byte_in;
          state_d = LEN_HI;
        end
        LEN_HI: begin
          len_d = len_n[ADDR_W:0];
          state_d = len_n > LEN_W'(DEPTH) ? ERR : len_n == '0 ? TAIL : DATA;
        end
        DATA: if (last_byte) begin
          addr_d = cnt_q[ADDR_W-1:0];
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          state_d = cnt_d == len_q ? TAIL : DATA;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: state_d = bus.byte_in == csum_q ? DONE : ERR;
`endif
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_lo_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_lo_q <= len_lo_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  assign bus.imem_we = word_valid;
  assign bus.imem_addr = addr_q;
  assign bus.imem_wdata = word;
  assign cpu_hold = state_q != DONE;
  assign done = state_q == DONE;
  assign error = state_q == ERR;
  assign word_count = cnt_q;
endmodule
